// File: rtl/spi_crc_link.sv
// spi_crc_link: SPI mode-0 master and slave joined by internal sck/ss_n/mosi/miso.
// Each side sends {word, crc8(word)} MSB first in one full-duplex frame.
// Optional receive-side CRC compare and error flags: define SPI_CRC_CHECK_EN.
module spi_crc_link #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned SCK_HALF   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in_master,
   input  logic [DATA_WIDTH-1:0] data_in_slave,
   input  logic                  start,
   output logic                  finish,
   output logic [DATA_WIDTH-1:0] data_out_master,
   output logic [DATA_WIDTH-1:0] data_out_slave
`ifdef SPI_CRC_CHECK_EN
   ,
   output logic                  crc_err_master,
   output logic                  crc_err_slave
`endif
);

   localparam int unsigned N  = DATA_WIDTH + 8;
   localparam int unsigned PW = $clog2(2 * SCK_HALF);
   localparam int unsigned BW = $clog2(N);
   localparam logic [PW-1:0] PH_LAST  = PW'(2 * SCK_HALF - 1);
   localparam logic [PW-1:0] PH_RISE  = PW'(SCK_HALF);
   localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

   // CRC-8, poly 0x07, init 0, MSB first, no reflection, no final XOR
   function automatic logic [7:0] f_crc8(input logic [DATA_WIDTH-1:0] d);
      logic [7:0] c;
      c = '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         if (c[7] ^ d[DATA_WIDTH-1-i]) c = {c[6:0], 1'b0} ^ 8'h07;
         else                          c = {c[6:0], 1'b0};
      end
      return c;
   endfunction

   // master state
   state_t            r_state, w_state_nxt;
   logic [PW-1:0]     r_ph, w_ph_nxt, w_ph_inc;
   logic [BW-1:0]     r_bit, w_bit_nxt;
   logic              r_sck, w_sck_nxt;
   logic              r_ss_n, w_ss_n_nxt;
   logic [N-1:0]      r_m_tx, w_m_tx_nxt;
   logic [N-1:0]      r_m_rx, w_m_rx_nxt;
   logic [DATA_WIDTH-1:0] r_dout_m, w_dout_m_nxt;
   logic              r_finish, w_finish_nxt;

   // slave state
   logic              r_ss_d;
   logic              r_sck_d;
   logic [N-1:0]      r_s_tx;
   logic [N-1:0]      r_s_rx;
   logic [DATA_WIDTH-1:0] r_dout_s;

   // link wires and slave event strobes
   logic              w_mosi, w_miso;
   logic              w_s_load, w_s_rise, w_s_fall, w_s_end;
   logic [DATA_WIDTH-1:0] w_m_rx_word, w_s_rx_word;

`ifdef SPI_CRC_CHECK_EN
   logic              r_err_m, w_err_m_nxt;
   logic              r_err_s;
   logic [7:0]        w_m_rx_crc, w_s_rx_crc;
   assign w_m_rx_crc = r_m_rx[7:0];
   assign w_s_rx_crc = r_s_rx[7:0];
`endif

   assign w_mosi      = r_m_tx[N-1];
   assign w_miso      = r_s_tx[N-1];
   assign w_m_rx_word = r_m_rx[N-1:8];
   assign w_s_rx_word = r_s_rx[N-1:8];
   assign w_ph_inc    = (r_ph == PH_LAST) ? '0 : r_ph + 1'b1;

   // Slave sees ss_n/sck one cycle late via r_ss_d/r_sck_d; its frame end uses the
   // master's next ss_n so both data_out registers update on the same edge.
   assign w_s_load = r_ss_d & ~r_ss_n;
   assign w_s_rise = ~r_ss_n &  r_sck & ~r_sck_d;
   assign w_s_fall = ~r_ss_n & ~r_sck &  r_sck_d;
   assign w_s_end  = ~r_ss_n & w_ss_n_nxt;

   // master next-state, sck generation, shifting and completion
   always_comb begin
      w_state_nxt  = r_state;
      w_ph_nxt     = r_ph;
      w_bit_nxt    = r_bit;
      w_sck_nxt    = r_sck;
      w_ss_n_nxt   = r_ss_n;
      w_m_tx_nxt   = r_m_tx;
      w_m_rx_nxt   = r_m_rx;
      w_dout_m_nxt = r_dout_m;
      w_finish_nxt = 1'b0;
`ifdef SPI_CRC_CHECK_EN
      w_err_m_nxt  = r_err_m;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_m_tx_nxt  = {data_in_master, f_crc8(data_in_master)};
               w_ss_n_nxt  = 1'b0;
               w_ph_nxt    = '0;
               w_bit_nxt   = '0;
               w_state_nxt = S_XFER;
            end
         end
         S_XFER: begin
            w_ph_nxt = w_ph_inc;
            if (w_ph_inc == PH_RISE) begin
               w_sck_nxt  = 1'b1;
               w_m_rx_nxt = {r_m_rx[N-2:0], w_miso};
            end else if (r_ph == PH_LAST) begin
               w_sck_nxt  = 1'b0;
               w_m_tx_nxt = {r_m_tx[N-2:0], 1'b0};
               if (r_bit == BIT_LAST) w_state_nxt = S_DONE;
               else                   w_bit_nxt   = r_bit + 1'b1;
            end
         end
         S_DONE: begin
            w_ss_n_nxt   = 1'b1;
            w_finish_nxt = 1'b1;
            w_state_nxt  = S_IDLE;
`ifdef SPI_CRC_CHECK_EN
            if (w_m_rx_crc == f_crc8(w_m_rx_word)) begin
               w_dout_m_nxt = w_m_rx_word;
               w_err_m_nxt  = 1'b0;
            end else begin
               w_err_m_nxt  = 1'b1;
            end
`else
            w_dout_m_nxt = w_m_rx_word;
`endif
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // master register bank
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_ph     <= '0;
         r_bit    <= '0;
         r_sck    <= 1'b0;
         r_ss_n   <= 1'b1;
         r_m_tx   <= '0;
         r_m_rx   <= '0;
         r_dout_m <= '0;
         r_finish <= 1'b0;
`ifdef SPI_CRC_CHECK_EN
         r_err_m  <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_ph     <= w_ph_nxt;
         r_bit    <= w_bit_nxt;
         r_sck    <= w_sck_nxt;
         r_ss_n   <= w_ss_n_nxt;
         r_m_tx   <= w_m_tx_nxt;
         r_m_rx   <= w_m_rx_nxt;
         r_dout_m <= w_dout_m_nxt;
         r_finish <= w_finish_nxt;
`ifdef SPI_CRC_CHECK_EN
         r_err_m  <= w_err_m_nxt;
`endif
      end
   end

   // slave: load on ss_n fall, shift on sck fall, sample on sck rise, commit at frame end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ss_d   <= 1'b1;
         r_sck_d  <= 1'b0;
         r_s_tx   <= '0;
         r_s_rx   <= '0;
         r_dout_s <= '0;
`ifdef SPI_CRC_CHECK_EN
         r_err_s  <= 1'b0;
`endif
      end else begin
         r_ss_d  <= r_ss_n;
         r_sck_d <= r_sck;
         if (w_s_load)      r_s_tx <= {data_in_slave, f_crc8(data_in_slave)};
         else if (w_s_fall) r_s_tx <= {r_s_tx[N-2:0], 1'b0};
         if (w_s_rise)      r_s_rx <= {r_s_rx[N-2:0], w_mosi};
         if (w_s_end) begin
`ifdef SPI_CRC_CHECK_EN
            if (w_s_rx_crc == f_crc8(w_s_rx_word)) begin
               r_dout_s <= w_s_rx_word;
               r_err_s  <= 1'b0;
            end else begin
               r_err_s  <= 1'b1;
            end
`else
            r_dout_s <= w_s_rx_word;
`endif
         end
      end
   end

   assign finish          = r_finish;
   assign data_out_master = r_dout_m;
   assign data_out_slave  = r_dout_s;
`ifdef SPI_CRC_CHECK_EN
   assign crc_err_master  = r_err_m;
   assign crc_err_slave   = r_err_s;
`endif

endmodule

// File: tb/tb_spi_crc_link.sv
// Self-checking bench for spi_crc_link (default parameters).
// Covers SPI_CRC_CHECK_EN builds too when the macro is defined.
module tb_spi_crc_link;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] dim = '0;
   logic [7:0] dis = '0;
   logic       start = 1'b0;
   logic       finish;
   logic [7:0] dom, dos;
`ifdef SPI_CRC_CHECK_EN
   logic       err_m, err_s;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int e0       = 0;

   logic [7:0] exp_dom = '0;
   logic [7:0] exp_dos = '0;

   // wire monitor state
   logic [15:0] mon_mosi = '0;
   logic [15:0] mon_miso = '0;
   int          mon_rises = 0;
   int          mon_last_rise = 0;
   int          mon_last_fall = 0;
   logic        mon_prev_sck = 1'b0;

   spi_crc_link #(.DATA_WIDTH(8), .SCK_HALF(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .data_in_master  (dim),
      .data_in_slave   (dis),
      .start           (start),
      .finish          (finish),
      .data_out_master (dom),
      .data_out_slave  (dos)
`ifdef SPI_CRC_CHECK_EN
      ,
      .crc_err_master  (err_m),
      .crc_err_slave   (err_s)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // capture mosi/miso bits at each sck rise
   always @(negedge clk) begin
      if (dut.r_sck && !mon_prev_sck) begin
         mon_mosi      <= {mon_mosi[14:0], dut.w_mosi};
         mon_miso      <= {mon_miso[14:0], dut.w_miso};
         mon_rises     <= mon_rises + 1;
         mon_last_rise <= cyc;
      end
      if (!dut.r_sck && mon_prev_sck) mon_last_fall <= cyc;
      mon_prev_sck <= dut.r_sck;
   end

   // reference CRC: remainder of (word * x^8) mod (x^8+x^2+x+1)
   function automatic logic [7:0] crc_ref(input logic [7:0] w);
      logic [15:0] r;
      r = {w, 8'h00};
      for (int b = 15; b >= 8; b--)
         if (r[b]) r = r ^ (16'h0107 << (b - 8));
      return r[7:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One frame starting at E0; observes 150 cycles after E0.
   task automatic run_frame(input logic [7:0] m, input logic [7:0] s, input int hold,
                            input int busy_at, input int rst_at, input int force_at,
                            input logic fbit, output int fin_k, output int fin_cnt);
      fin_k   = -1;
      fin_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      dim   = m;
      @(posedge clk);
      @(negedge clk);
      e0    = cyc;
      start = (hold > 1);
      dis   = s;
      dim   = 8'($urandom);
      for (int k = 1; k <= 150; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (finish) begin
            fin_cnt++;
            if (fin_k < 0) fin_k = k;
         end
         if (k == 1) begin
            start = 1'b0;
            dis   = 8'($urandom);
         end
         if (busy_at > 0 && k == busy_at - 1) start = 1'b1;
         if (busy_at > 0 && k == busy_at)     start = 1'b0;
         if (rst_at > 0 && k == rst_at - 1)   rst = 1'b1;
         if (rst_at > 0 && k == rst_at) begin
            rst = 1'b0;
            chk("abort_finish", 32'(finish), 32'd0);
            chk("abort_dout_m", 32'(dom), 32'd0);
            chk("abort_dout_s", 32'(dos), 32'd0);
            chk("abort_sck", 32'(dut.r_sck), 32'd0);
            chk("abort_ss_n", 32'(dut.r_ss_n), 32'd1);
         end
`ifdef SPI_CRC_CHECK_EN
         if (force_at > 0 && k == force_at)     force dut.w_miso = fbit;
         if (force_at > 0 && k == force_at + 5) release dut.w_miso;
`else
         if (force_at > 0 && k == force_at && fbit) dim = dim;
`endif
      end
   endtask

   task automatic post_checks(input logic [7:0] m, input logic [7:0] s,
                              input int fin_k, input int fin_cnt, input int rises0);
      logic [15:0] fm, fs;
      fm = {m, crc_ref(m)};
      fs = {s, crc_ref(s)};
      exp_dos = m;
      exp_dom = s;
      chk("latency", 32'(fin_k), 32'd129);
      chk("finish_count", 32'(fin_cnt), 32'd1);
      chk("dout_slave", 32'(dos), 32'(exp_dos));
      chk("dout_master", 32'(dom), 32'(exp_dom));
      chk("mosi_frame", 32'(mon_mosi), 32'(fm));
      chk("miso_frame", 32'(mon_miso), 32'(fs));
      chk("sck_rises", 32'(mon_rises - rises0), 32'd16);
      chk("last_rise", 32'(mon_last_rise - e0), 32'd124);
      chk("last_fall", 32'(mon_last_fall - e0), 32'd128);
      chk("ss_n_idle", 32'(dut.r_ss_n), 32'd1);
`ifdef SPI_CRC_CHECK_EN
      chk("err_master", 32'(err_m), 32'd0);
      chk("err_slave", 32'(err_s), 32'd0);
`endif
   endtask

   typedef struct {
      logic [7:0]  m;
      logic [7:0]  s;
      logic [15:0] mosi;
      logic [15:0] miso;
   } vec_t;

   vec_t tbl[4];

   initial begin
      int fk, fc, r0;
      logic [7:0] m, s;
      logic [15:0] fr;

      tbl[0] = '{8'hD7, 8'hF5, 16'hD72B, 16'hF5C5};
      tbl[1] = '{8'h00, 8'h01, 16'h0000, 16'h0107};
      tbl[2] = '{8'h80, 8'hD7, 16'h8089, 16'hD72B};
      tbl[3] = '{8'hF5, 8'h80, 16'hF5C5, 16'h8089};

      // reset held three cycles
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_finish", 32'(finish), 32'd0);
      chk("rst_dout_m", 32'(dom), 32'd0);
      chk("rst_dout_s", 32'(dos), 32'd0);
      chk("rst_sck", 32'(dut.r_sck), 32'd0);
      chk("rst_ss_n", 32'(dut.r_ss_n), 32'd1);
      chk("rst_mosi", 32'(dut.w_mosi), 32'd0);
      chk("rst_miso", 32'(dut.w_miso), 32'd0);
`ifdef SPI_CRC_CHECK_EN
      chk("rst_err_m", 32'(err_m), 32'd0);
      chk("rst_err_s", 32'(err_s), 32'd0);
`endif

      // table-driven frames with known wire images
      for (int i = 0; i < 4; i++) begin
         r0 = mon_rises;
         run_frame(tbl[i].m, tbl[i].s, 1, 0, 0, 0, 1'b0, fk, fc);
         chk("tbl_mosi", 32'(mon_mosi), 32'(tbl[i].mosi));
         chk("tbl_miso", 32'(mon_miso), 32'(tbl[i].miso));
         chk("tbl_dout_s", 32'(dos), 32'(tbl[i].m));
         chk("tbl_dout_m", 32'(dom), 32'(tbl[i].s));
         post_checks(tbl[i].m, tbl[i].s, fk, fc, r0);
      end

      // loopback: start held two cycles, second is ignored
      r0 = mon_rises;
      run_frame(8'hF5, 8'hD7, 2, 0, 0, 0, 1'b0, fk, fc);
      post_checks(8'hF5, 8'hD7, fk, fc, r0);

      // busy: start pulse at E40 must not restart the frame
      r0 = mon_rises;
      run_frame(8'h3C, 8'hA5, 1, 40, 0, 0, 1'b0, fk, fc);
      post_checks(8'h3C, 8'hA5, fk, fc, r0);

      // reset at E60 aborts the frame with no finish
      run_frame(8'h12, 8'h34, 1, 0, 60, 0, 1'b0, fk, fc);
      chk("abort_no_finish", 32'(fc), 32'd0);
      exp_dom = '0;
      exp_dos = '0;
      chk("abort_hold_m", 32'(dom), 32'(exp_dom));
      chk("abort_hold_s", 32'(dos), 32'(exp_dos));

      // fresh frame after the abort
      r0 = mon_rises;
      run_frame(8'h5A, 8'hC3, 1, 0, 0, 0, 1'b0, fk, fc);
      post_checks(8'h5A, 8'hC3, fk, fc, r0);

      // randomized frames against the reference CRC model
      for (int i = 0; i < 8; i++) begin
         m  = 8'($urandom);
         s  = 8'($urandom);
         r0 = mon_rises;
         run_frame(m, s, 1, 0, 0, 0, 1'b0, fk, fc);
         post_checks(m, s, fk, fc, r0);
      end

`ifdef SPI_CRC_CHECK_EN
      // corrupt miso bit 12 (inside the CRC byte) seen by the master
      s  = 8'hF5;
      fr = {s, crc_ref(s)};
      run_frame(8'hD7, s, 1, 0, 0, 98, ~fr[3], fk, fc);
      chk("err_latency", 32'(fk), 32'd129);
      chk("err_finish_count", 32'(fc), 32'd1);
      chk("err_flag_m", 32'(err_m), 32'd1);
      chk("err_flag_s", 32'(err_s), 32'd0);
      chk("err_dout_m_held", 32'(dom), 32'(exp_dom));
      chk("err_dout_s", 32'(dos), 32'h0000_00D7);
      exp_dos = 8'hD7;
      // next clean frame clears the sticky flag
      r0 = mon_rises;
      run_frame(8'h69, 8'h96, 1, 0, 0, 0, 1'b0, fk, fc);
      post_checks(8'h69, 8'h96, fk, fc, r0);
`else
      fr = '0;
      s  = fr[7:0];
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
